// File: rtl/sprite_overlay_gen.sv
// -----------------------------------------------------------------------------
// sprite_overlay_gen
//
// Multi-sprite overlay generator for the VGA pixel pipeline. NUM_SPR
// rectangular windows are placed independently on the screen. For every pixel
// the block checks which windows contain it, drives one external ROM address
// per sprite, and merges the returned ROM data into a registered 12-bit RGB
// output. Sprite 0 has the highest priority. Each sprite can be enabled, set
// to blink, and can use a colour key for transparent pixels.
//
// Pipeline (one pixel per clock, latency ROM_LAT+2 clocks):
//   stage 0 (comb)   : hit test from i_x/i_y against every window
//   stage 1 (reg)    : ROM addresses, hit vector and de registered
//   align  (reg x L) : hit vector and de delayed ROM_LAT clocks to meet ROM data
//   merge  (comb)    : priority / transparency / background selection
//   output (reg)     : o_red/o_green/o_blue and o_de
//
// Ports:
//   i_clk          pixel clock
//   i_rst          asynchronous active-high reset
//   i_x, i_y       current pixel coordinate
//   i_de           active-video flag for i_x/i_y
//   i_frame_start  one-clock pulse at the start of each frame (drives blink)
//   i_spr_x0/y0    packed top-left corner of each sprite ([k*W +: W])
//   i_spr_en       per-sprite visible enable
//   i_spr_blink    per-sprite blink mode
//   o_rom_addr     packed ROM address per sprite (0 when the sprite is not hit)
//   i_rom_data     packed ROM data {R,G,B} per sprite, ROM_LAT clocks after addr
//   o_red/green/blue  registered output colour
//   o_de           i_de delayed to line up with the colour
// -----------------------------------------------------------------------------
module sprite_overlay_gen #(
    parameter int          NUM_SPR      = 2,
    parameter int          SPR_W        = 120,
    parameter int          SPR_H        = 120,
    parameter int          ADDR_W       = 14,
    parameter int          X_W          = 11,
    parameter int          Y_W          = 10,
    parameter int          ROM_LAT      = 1,
    parameter int          TRANSP_EN    = 1,
    parameter logic [11:0] TRANSP_KEY   = 12'h000,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [X_W-1:0]              i_x,
    input  logic [Y_W-1:0]              i_y,
    input  logic                        i_de,
    input  logic                        i_frame_start,
    input  logic [NUM_SPR*X_W-1:0]      i_spr_x0,
    input  logic [NUM_SPR*Y_W-1:0]      i_spr_y0,
    input  logic [NUM_SPR-1:0]          i_spr_en,
    input  logic [NUM_SPR-1:0]          i_spr_blink,
    output logic [NUM_SPR*ADDR_W-1:0]   o_rom_addr,
    input  logic [NUM_SPR*12-1:0]       i_rom_data,
    output logic [3:0]                  o_red,
    output logic [3:0]                  o_green,
    output logic [3:0]                  o_blue,
    output logic                        o_de
);

    // One extra bit on the window comparisons so x0+SPR_W / y0+SPR_H can
    // never wrap around and falsely match pixels near the origin.
    localparam int XC_W = X_W + 1;
    localparam int YC_W = Y_W + 1;

    localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    // -------------------------------------------------------------------------
    // Blink timing: frame counter wraps every BLINK_FRAMES frame starts and
    // flips the blink phase on each wrap.
    // -------------------------------------------------------------------------
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (i_frame_start) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 0: per-sprite hit test and ROM address
    // -------------------------------------------------------------------------
    logic [XC_W-1:0]     x_ext;
    logic [YC_W-1:0]     y_ext;
    logic [XC_W-1:0]     x_lo   [NUM_SPR];
    logic [XC_W-1:0]     x_hi   [NUM_SPR];
    logic [YC_W-1:0]     y_lo   [NUM_SPR];
    logic [YC_W-1:0]     y_hi   [NUM_SPR];
    logic [X_W-1:0]      dx     [NUM_SPR];
    logic [Y_W-1:0]      dy     [NUM_SPR];
    logic [NUM_SPR-1:0]  in_x;
    logic [NUM_SPR-1:0]  in_y;
    logic [NUM_SPR-1:0]  hit_s0;
    logic [ADDR_W-1:0]   addr_s0 [NUM_SPR];

    assign x_ext = {1'b0, i_x};
    assign y_ext = {1'b0, i_y};

    // NOTE: every output of this block gets a default before the loop, so no
    // path through it can leave a value held and infer a latch.
    always_comb begin
        in_x   = '0;
        in_y   = '0;
        hit_s0 = '0;
        for (int k = 0; k < NUM_SPR; k++) begin
            x_lo[k]    = {1'b0, i_spr_x0[k*X_W +: X_W]};
            y_lo[k]    = {1'b0, i_spr_y0[k*Y_W +: Y_W]};
            x_hi[k]    = x_lo[k] + XC_W'(SPR_W);
            y_hi[k]    = y_lo[k] + YC_W'(SPR_H);
            dx[k]      = i_x - i_spr_x0[k*X_W +: X_W];
            dy[k]      = i_y - i_spr_y0[k*Y_W +: Y_W];
            addr_s0[k] = '0;

            // x0 <= x <= x0+SPR_W-1 written as x < x0+SPR_W on widened values
            in_x[k] = (x_ext >= x_lo[k]) && (x_ext < x_hi[k]);
            in_y[k] = (y_ext >= y_lo[k]) && (y_ext < y_hi[k]);

            hit_s0[k] = i_de && i_spr_en[k] && !(i_spr_blink[k] && blink_phase)
                        && in_x[k] && in_y[k];

            // Address arithmetic is modular, so evaluating it at ADDR_W bits
            // gives the same result as truncating the full-width product.
            if (hit_s0[k]) begin
                addr_s0[k] = ADDR_W'(dy[k]) * ADDR_W'(SPR_W) + ADDR_W'(dx[k]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: registered ROM addresses, hit vector and de
    // -------------------------------------------------------------------------
    logic [NUM_SPR-1:0] hit_s1;
    logic               de_s1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rom_addr <= '0;
            hit_s1     <= '0;
            de_s1      <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SPR; k++) begin
                o_rom_addr[k*ADDR_W +: ADDR_W] <= addr_s0[k];
            end
            hit_s1 <= hit_s0;
            de_s1  <= i_de;
        end
    end

    // -------------------------------------------------------------------------
    // Alignment: delay hit vector and de by ROM_LAT clocks so they arrive
    // together with the ROM data for the same pixel.
    // -------------------------------------------------------------------------
    logic [NUM_SPR-1:0] hit_dly [ROM_LAT];
    logic [ROM_LAT-1:0] de_dly;
    logic [NUM_SPR-1:0] hit_al;
    logic               de_al;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                hit_dly[i] <= '0;
            end
            de_dly <= '0;
        end else begin
            hit_dly[0] <= hit_s1;
            de_dly[0]  <= de_s1;
            for (int i = 1; i < ROM_LAT; i++) begin
                hit_dly[i] <= hit_dly[i-1];
                de_dly[i]  <= de_dly[i-1];
            end
        end
    end

    assign hit_al = hit_dly[ROM_LAT-1];
    assign de_al  = de_dly[ROM_LAT-1];

    // -------------------------------------------------------------------------
    // Merge: lowest-numbered visible, non-transparent sprite wins; otherwise
    // background. Blanking forces black.
    // -------------------------------------------------------------------------
    logic [11:0] rom_px [NUM_SPR];
    logic [11:0] merged;
    logic        found;

    always_comb begin
        merged = BG_COLOR;
        found  = 1'b0;
        for (int k = 0; k < NUM_SPR; k++) begin
            rom_px[k] = i_rom_data[k*12 +: 12];
            if (!found && hit_al[k] &&
                ((TRANSP_EN == 0) || (rom_px[k] != TRANSP_KEY))) begin
                merged = rom_px[k];
                found  = 1'b1;
            end
        end
        if (!de_al) begin
            merged = 12'h000;
        end
    end

    // -------------------------------------------------------------------------
    // Output register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_red   <= 4'h0;
            o_green <= 4'h0;
            o_blue  <= 4'h0;
            o_de    <= 1'b0;
        end else begin
            {o_red, o_green, o_blue} <= merged;
            o_de                     <= de_al;
        end
    end

endmodule

// File: tb/tb_sprite_overlay_gen.sv
// -----------------------------------------------------------------------------
// tb_sprite_overlay_gen
//
// Self-checking bench for sprite_overlay_gen. A behavioural ROM supplies pixel
// data with ROM_LAT clocks of latency. Expected addresses and colours come from
// a per-pixel reference model that evaluates the window / priority /
// transparency / blink rules directly on integer coordinates.
// -----------------------------------------------------------------------------
module tb_sprite_overlay_gen;

    localparam int          NUM_SPR      = 2;
    localparam int          SPR_W        = 120;
    localparam int          SPR_H        = 120;
    localparam int          ADDR_W       = 14;
    localparam int          X_W          = 11;
    localparam int          Y_W          = 10;
    localparam int          ROM_LAT      = 1;
    localparam int          TRANSP_EN    = 1;
    localparam logic [11:0] TRANSP_KEY   = 12'h000;
    localparam logic [11:0] BG_COLOR     = 12'h00F;
    localparam int          BLINK_FRAMES = 30;

    localparam int LAT   = ROM_LAT + 2;
    localparam int DEPTH = SPR_W * SPR_H;
    localparam int X_MAX = (1 << X_W) - 1;
    localparam int Y_MAX = (1 << Y_W) - 1;

    logic                      i_clk;
    logic                      i_rst;
    logic [X_W-1:0]            i_x;
    logic [Y_W-1:0]            i_y;
    logic                      i_de;
    logic                      i_frame_start;
    logic [NUM_SPR*X_W-1:0]    i_spr_x0;
    logic [NUM_SPR*Y_W-1:0]    i_spr_y0;
    logic [NUM_SPR-1:0]        i_spr_en;
    logic [NUM_SPR-1:0]        i_spr_blink;
    logic [NUM_SPR*ADDR_W-1:0] o_rom_addr;
    logic [NUM_SPR*12-1:0]     i_rom_data;
    logic [3:0]                o_red;
    logic [3:0]                o_green;
    logic [3:0]                o_blue;
    logic                      o_de;

    sprite_overlay_gen #(
        .NUM_SPR      (NUM_SPR),
        .SPR_W        (SPR_W),
        .SPR_H        (SPR_H),
        .ADDR_W       (ADDR_W),
        .X_W          (X_W),
        .Y_W          (Y_W),
        .ROM_LAT      (ROM_LAT),
        .TRANSP_EN    (TRANSP_EN),
        .TRANSP_KEY   (TRANSP_KEY),
        .BG_COLOR     (BG_COLOR),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_de          (i_de),
        .i_frame_start (i_frame_start),
        .i_spr_x0      (i_spr_x0),
        .i_spr_y0      (i_spr_y0),
        .i_spr_en      (i_spr_en),
        .i_spr_blink   (i_spr_blink),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (i_rom_data),
        .o_red         (o_red),
        .o_green       (o_green),
        .o_blue        (o_blue),
        .o_de          (o_de)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Behavioural sprite ROMs with ROM_LAT clocks of read latency
    // ------------------------------------------------------------------
    logic [11:0] rom_mem  [NUM_SPR][DEPTH];
    logic [11:0] rom_pipe [NUM_SPR][ROM_LAT];

    function automatic logic [11:0] rom_rd(input int k, input logic [ADDR_W-1:0] a);
        if (int'(a) < DEPTH) return rom_mem[k][int'(a)];
        return 12'h000;
    endfunction

    always @(posedge i_clk) begin
        for (int k = 0; k < NUM_SPR; k++) begin
            rom_pipe[k][0] <= rom_rd(k, o_rom_addr[k*ADDR_W +: ADDR_W]);
            for (int i = 1; i < ROM_LAT; i++) rom_pipe[k][i] <= rom_pipe[k][i-1];
        end
    end

    always_comb begin
        i_rom_data = '0;
        for (int k = 0; k < NUM_SPR; k++) i_rom_data[k*12 +: 12] = rom_pipe[k][ROM_LAT-1];
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [11:0]               rgb;
        logic                      de;
        logic [NUM_SPR*ADDR_W-1:0] addr;
    } exp_t;

    int         m_x0 [NUM_SPR];
    int         m_y0 [NUM_SPR];
    bit [NUM_SPR-1:0] m_en;
    bit [NUM_SPR-1:0] m_blink;
    int         m_frames;           // frame starts seen since reset

    exp_t exp_q[$];
    int   total;
    int   bad;

    function automatic exp_t model(input int x, input int y, input bit de);
        exp_t e;
        bit   hidden_phase;
        bit   vis;
        int   a;
        logic [11:0] c;
        e = '0;
        e.de = de;
        e.rgb = de ? BG_COLOR : 12'h000;
        hidden_phase = ((m_frames / BLINK_FRAMES) % 2) == 1;
        // Walk from the lowest priority upwards so sprite 0 is written last.
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            vis = de && m_en[k] && !(m_blink[k] && hidden_phase) &&
                  x >= m_x0[k] && x < m_x0[k] + SPR_W &&
                  y >= m_y0[k] && y < m_y0[k] + SPR_H;
            if (vis) begin
                a = ((y - m_y0[k]) * SPR_W + (x - m_x0[k])) % (1 << ADDR_W);
                e.addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
                c = rom_mem[k][a];
                if (!(TRANSP_EN != 0 && c == TRANSP_KEY)) e.rgb = c;
            end
        end
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // One pixel per call: check the outputs due now, then present a new pixel.
    task automatic step(input int x, input int y, input bit de, input bit fs);
        exp_t f;
        exp_t e;
        int   xv;
        int   yv;
        @(negedge i_clk);
        if (exp_q.size() == LAT) begin
            f = exp_q.pop_front();
            total++;
            assert ({o_red, o_green, o_blue} === f.rgb) else begin
                bad++;
                $error("FAIL rgb: got %h want %h", {o_red, o_green, o_blue}, f.rgb);
            end
            total++;
            assert (o_de === f.de) else begin
                bad++;
                $error("FAIL de: got %b want %b", o_de, f.de);
            end
        end
        if (exp_q.size() != 0) begin
            total++;
            assert (o_rom_addr === exp_q[$].addr) else begin
                bad++;
                $error("FAIL rom_addr: got %h want %h", o_rom_addr, exp_q[$].addr);
            end
        end
        xv = x & X_MAX;
        yv = y & Y_MAX;
        for (int k = 0; k < NUM_SPR; k++) begin
            i_spr_x0[k*X_W +: X_W] = X_W'(m_x0[k]);
            i_spr_y0[k*Y_W +: Y_W] = Y_W'(m_y0[k]);
        end
        i_spr_en      = m_en;
        i_spr_blink   = m_blink;
        i_x           = X_W'(xv);
        i_y           = Y_W'(yv);
        i_de          = de;
        i_frame_start = fs;
        e = model(xv, yv, de);
        exp_q.push_back(e);
        if (fs) m_frames++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    // Address of sprite k one clock after presenting (x,y).
    task automatic probe_addr(input int x, input int y, input int k,
                              input logic [ADDR_W-1:0] want);
        step(x, y, 1'b1, 1'b0);
        @(posedge i_clk);
        #1;
        total++;
        assert (o_rom_addr[k*ADDR_W +: ADDR_W] === want) else begin
            bad++;
            $error("FAIL addr%0d(%0d,%0d): got %0d want %0d", k, x, y,
                   o_rom_addr[k*ADDR_W +: ADDR_W], want);
        end
    endtask

    // Colour and de exactly LAT clocks after presenting (x,y,de).
    task automatic probe_pix(input int x, input int y, input bit de,
                             input logic [11:0] want_rgb, input bit want_de);
        step(x, y, de, 1'b0);
        repeat (LAT - 1) step(x, y, de, 1'b0);
        @(posedge i_clk);
        #1;
        total++;
        assert ({o_red, o_green, o_blue} === want_rgb) else begin
            bad++;
            $error("FAIL pix(%0d,%0d): got %h want %h", x, y,
                   {o_red, o_green, o_blue}, want_rgb);
        end
        total++;
        assert (o_de === want_de) else begin
            bad++;
            $error("FAIL pix_de(%0d,%0d): got %b want %b", x, y, o_de, want_de);
        end
    endtask

    // Assert reset (async), check the cleared outputs, release on a falling edge.
    task automatic do_reset();
        exp_t z;
        z = '0;
        i_rst         = 1'b1;
        i_de          = 1'b0;
        i_frame_start = 1'b0;
        m_frames      = 0;
        #1;
        total++;
        assert ({o_red, o_green, o_blue, o_de} === 13'h0) else begin
            bad++;
            $error("FAIL reset_rgb_de: got %h want 0", {o_red, o_green, o_blue, o_de});
        end
        total++;
        assert (o_rom_addr === '0) else begin
            bad++;
            $error("FAIL reset_addr: got %h want 0", o_rom_addr);
        end
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        for (int i = 0; i < LAT; i++) exp_q.push_back(z);
        i_rst = 1'b0;
    endtask

    task automatic fill_rom_random();
        for (int k = 0; k < NUM_SPR; k++)
            for (int i = 0; i < DEPTH; i++)
                rom_mem[k][i] = ($urandom_range(0, 7) == 0) ? TRANSP_KEY : 12'($urandom);
    endtask

    task automatic fill_rom_const(input int k, input logic [11:0] c);
        for (int i = 0; i < DEPTH; i++) rom_mem[k][i] = c;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int rows [6] = '{0, 1, 60, 119, 120, 479};
    int kk;

    initial begin
        total = 0;
        bad   = 0;
        i_rst = 1'b1;
        i_x = '0; i_y = '0; i_de = 1'b0; i_frame_start = 1'b0;
        i_spr_x0 = '0; i_spr_y0 = '0; i_spr_en = '0; i_spr_blink = '0;
        m_x0 = '{520, 400};
        m_y0 = '{0, 0};
        m_en = 2'b11;
        m_blink = 2'b00;
        m_frames = 0;
        fill_rom_random();
        for (int k = 0; k < NUM_SPR; k++)
            for (int i = 0; i < ROM_LAT; i++) rom_pipe[k][i] = 12'h000;
        #2;
        do_reset();

        // Default placement, scan selected full lines including window edges.
        foreach (rows[r]) begin
            for (int x = 0; x < 640; x++) step(x, rows[r], 1'b1, 1'b0);
            idle(6);
        end
        probe_addr(520, 0, 0, 14'd0);
        probe_addr(639, 119, 0, 14'd14399);
        probe_addr(400, 119, 1, 14'd14280);

        // Random placements, enables, blink and frame pulses.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                for (int k = 0; k < NUM_SPR; k++) begin
                    m_x0[k] = $urandom_range(0, X_MAX);
                    m_y0[k] = $urandom_range(0, Y_MAX);
                    if ($urandom_range(0, 1) == 0) begin
                        m_x0[k] = $urandom_range(0, 600);
                        m_y0[k] = m_y0[0];
                    end
                end
                m_en    = NUM_SPR'($urandom);
                m_blink = NUM_SPR'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                kk = $urandom_range(0, NUM_SPR - 1);
                step(m_x0[kk] + $urandom_range(0, SPR_W + 7) - 4,
                     m_y0[kk] + $urandom_range(0, SPR_H + 7) - 4,
                     $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
            end else begin
                step($urandom_range(0, X_MAX), $urandom_range(0, Y_MAX),
                     $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
            end
        end

        // Priority and transparency with overlapping windows.
        idle(LAT + 1);
        do_reset();
        fill_rom_const(0, 12'hF00);
        fill_rom_const(1, 12'h0F0);
        m_x0 = '{100, 100};
        m_y0 = '{100, 100};
        m_en = 2'b11;
        m_blink = 2'b00;
        probe_pix(110, 110, 1'b1, 12'hF00, 1'b1);
        probe_pix(100, 100, 1'b1, 12'hF00, 1'b1);
        probe_pix(219, 219, 1'b1, 12'hF00, 1'b1);
        probe_pix(220, 100, 1'b1, BG_COLOR, 1'b1);
        probe_pix(99, 100, 1'b1, BG_COLOR, 1'b1);
        idle(LAT + 1);
        fill_rom_const(0, 12'h000);
        probe_pix(110, 110, 1'b1, 12'h0F0, 1'b1);

        // Background and blanking with nothing enabled.
        idle(LAT + 1);
        fill_rom_const(0, 12'hF00);
        m_en = 2'b00;
        probe_pix(50, 50, 1'b1, BG_COLOR, 1'b1);
        probe_pix(50, 50, 1'b0, 12'h000, 1'b0);

        // Blink: sprite 0 hidden after 30th frame start, back after 60th.
        idle(LAT + 1);
        do_reset();
        m_en = 2'b11;
        m_blink = 2'b01;
        repeat (29) step(0, 0, 1'b0, 1'b1);
        probe_pix(110, 110, 1'b1, 12'hF00, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        probe_pix(110, 110, 1'b1, 12'h0F0, 1'b1);
        repeat (29) step(0, 0, 1'b0, 1'b1);
        probe_pix(110, 110, 1'b1, 12'h0F0, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        probe_pix(110, 110, 1'b1, 12'hF00, 1'b1);

        // Reset mid-line while sprite 0 is in its hidden blink phase.
        repeat (30) step(0, 0, 1'b0, 1'b1);
        m_x0 = '{520, 400};
        m_y0 = '{0, 0};
        for (int x = 500; x <= 530; x++) step(x, 50, 1'b1, 1'b0);
        @(posedge i_clk);
        #1;
        do_reset();
        probe_addr(560, 60, 0, 14'd7240);
        probe_pix(560, 60, 1'b1, 12'hF00, 1'b1);
        idle(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
